// File: rtl/rob_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rob_ctrl_pkg : shared ROB types and sizing                           |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`ifndef RobDepth
`define RobDepth 8
`endif

package rob_ctrl_pkg;

  typedef logic [4:0] RegFile_t;

  localparam int ROB_DEPTH = `RobDepth;

  typedef logic [$clog2(`RobDepth)-1:0] RobTag_t;

  typedef struct packed {
    logic     valid;
    logic     done;
    logic     exp;
    logic     wv;
    RegFile_t rd;
  } RobEnt_t;

endpackage

`default_nettype wire

// File: rtl/rob_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rob_ctrl_if : dispatch / writeback / retire signalling of the ROB    |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface rob_ctrl_if
  import rob_ctrl_pkg::*;
#(
  parameter int REG  = $bits(RegFile_t),
  parameter int ADDR = $clog2(`RobDepth)
) ();

  logic            dis_e_;
  logic            dis_wv;
  logic [REG-1:0]  dis_rd;
  logic            dis_ready;
  logic [ADDR-1:0] dis_tag;

  logic            wb_e_;
  logic [ADDR-1:0] wb_tag;
  logic            wb_exp;

  logic            com_e_;
  logic [ADDR-1:0] com_tag;
  logic            com_wv;
  logic [REG-1:0]  com_rd;
  logic            inv_e_;
  logic [ADDR-1:0] inv_addr;
  logic            exc_req_;
  logic            empty;

  modport master (
    output dis_e_, dis_wv, dis_rd, wb_e_, wb_tag, wb_exp,
    input  dis_ready, dis_tag, com_e_, com_tag, com_wv, com_rd,
           inv_e_, inv_addr, exc_req_, empty
  );

  modport slave (
    input  dis_e_, dis_wv, dis_rd, wb_e_, wb_tag, wb_exp,
    output dis_ready, dis_tag, com_e_, com_tag, com_wv, com_rd,
           inv_e_, inv_addr, exc_req_, empty
  );

endinterface

`default_nettype wire

// File: rtl/rob_ptr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rob_ptr : circular head/tail pointers with occupancy counter         |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rob_ptr #(
  parameter int DEPTH = 8,
  parameter int ADDR  = $clog2(DEPTH)
) (
  input  wire logic            clk,
  input  wire logic            reset_,
  input  wire logic            clear,
  input  wire logic            inc_head,
  input  wire logic            inc_tail,
  output logic [ADDR-1:0]      head,
  output logic [ADDR-1:0]      tail,
  output logic [ADDR:0]        cnt,
  output logic                 full,
  output logic                 empty
);

  logic [ADDR-1:0] head_q, head_d;
  logic [ADDR-1:0] tail_q, tail_d;
  logic [ADDR:0]   cnt_q, cnt_d;

  // DEPTH is a power of two, so pointer wrap is plain overflow
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (clear) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      if (inc_head) head_d = head_q + ADDR'(1);
      if (inc_tail) tail_d = tail_q + ADDR'(1);
      cnt_d = cnt_q + (ADDR+1)'(inc_tail) - (ADDR+1)'(inc_head);
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head  = head_q;
  assign tail  = tail_q;
  assign cnt   = cnt_q;
  assign full  = (cnt_q == (ADDR+1)'(DEPTH));
  assign empty = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/rob_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rob_ctrl : reorder-buffer allocation, completion and in-order retire |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rob_ctrl
  import rob_ctrl_pkg::*;
#(
  parameter int REG   = $bits(RegFile_t),
  parameter int DEPTH = `RobDepth,
  parameter int ADDR  = $clog2(DEPTH)
) (
  input  wire logic   clk,
  input  wire logic   reset_,
  input  wire logic   flush_,
  rob_ctrl_if.slave   bus
);

  RobEnt_t         ent_q [DEPTH];
  RobEnt_t         ent_d [DEPTH];
  RobEnt_t         head_ent;
  logic [ADDR-1:0] head, tail;
  logic [ADDR:0]   cnt;
  logic            full, empty;
  logic            accept_dis, retire, wb_hit;
  logic [DEPTH-1:0] valid_vec;

  rob_ptr #(.DEPTH(DEPTH), .ADDR(ADDR)) u_ptr (
    .clk      (clk),
    .reset_   (reset_),
    .clear    (!flush_),
    .inc_head (retire),
    .inc_tail (accept_dis),
    .head     (head),
    .tail     (tail),
    .cnt      (cnt),
    .full     (full),
    .empty    (empty)
  );

  assign head_ent   = ent_q[head];
  assign accept_dis = flush_ && !bus.dis_e_ && !full;
  assign retire     = head_ent.valid && head_ent.done && !head_ent.exp;
  assign wb_hit     = !bus.wb_e_ && ent_q[bus.wb_tag].valid
                      && !(accept_dis && (bus.wb_tag == tail));

  // Writeback is applied before retire so a same-cycle retire still frees head
  always_comb begin
    for (int i = 0; i < DEPTH; i++) ent_d[i] = ent_q[i];
    if (!flush_) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
    end else begin
      if (wb_hit) begin
        ent_d[bus.wb_tag].done = 1'b1;
        ent_d[bus.wb_tag].exp  = bus.wb_exp;
      end
      if (retire) ent_d[head].valid = 1'b0;
      if (accept_dis) begin
        ent_d[tail].valid = 1'b1;
        ent_d[tail].done  = 1'b0;
        ent_d[tail].exp   = 1'b0;
        ent_d[tail].wv    = bus.dis_wv;
        ent_d[tail].rd    = RegFile_t'(bus.dis_rd);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

  always_comb begin
    valid_vec = '0;
    for (int i = 0; i < DEPTH; i++) valid_vec[i] = ent_q[i].valid;
  end

  assign bus.dis_ready = !full;
  assign bus.dis_tag   = tail;
  assign bus.com_e_    = !retire;
  assign bus.com_tag   = head;
  assign bus.com_wv    = head_ent.wv;
  assign bus.com_rd    = REG'(head_ent.rd);
  assign bus.inv_e_    = !(retire && head_ent.wv);
  assign bus.inv_addr  = head;
  assign bus.exc_req_  = !(head_ent.valid && head_ent.done && head_ent.exp);
  assign bus.empty     = empty;

  a_full_consistent : assert property (@(posedge clk) disable iff (!reset_)
    (cnt == (ADDR+1)'(DEPTH)) |-> ((head == tail) && (&valid_vec)));

endmodule

`default_nettype wire

// File: tb/tb_rob_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rob_ctrl : directed vectors for rob_ctrl at DEPTH=8               |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_rob_ctrl;

  logic clk = 1'b0;
  logic reset_;
  logic flush_;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  rob_ctrl_if #(.REG(5), .ADDR(3)) bus ();

  rob_ctrl #(.REG(5), .DEPTH(8)) dut (
    .clk    (clk),
    .reset_ (reset_),
    .flush_ (flush_),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.dis_e_ = 1'b1;
    bus.wb_e_  = 1'b1;
    bus.wb_exp = 1'b0;
    flush_     = 1'b1;
  endtask

  initial begin
    reset_     = 1'b0;
    flush_     = 1'b1;
    bus.dis_e_ = 1'b1;
    bus.dis_wv = 1'b0;
    bus.dis_rd = '0;
    bus.wb_e_  = 1'b1;
    bus.wb_tag = '0;
    bus.wb_exp = 1'b0;

    #12;
    check("rst_dis_ready", bus.dis_ready, 1);
    check("rst_dis_tag",   bus.dis_tag,   0);
    check("rst_com_e_",    bus.com_e_,    1);
    check("rst_inv_e_",    bus.inv_e_,    1);
    check("rst_exc_req_",  bus.exc_req_,  1);
    check("rst_empty",     bus.empty,     1);
    check("rst_com_wv",    bus.com_wv,    0);
    check("rst_com_rd",    bus.com_rd,    0);
    check("rst_com_tag",   bus.com_tag,   0);
    reset_ = 1'b1;
    tick();

    // fill: rd 1..8 on tags 0..7
    for (int i = 0; i < 8; i++) begin
      bus.dis_e_ = 1'b0;
      bus.dis_wv = 1'b1;
      bus.dis_rd = 5'(i + 1);
      #1;
      check("fill_tag",   bus.dis_tag,   i);
      check("fill_ready", bus.dis_ready, 1);
      tick();
    end
    bus.dis_e_ = 1'b1;
    #1;
    check("full_ready", bus.dis_ready, 0);
    check("full_cnt",   dut.u_ptr.cnt_q, 8);
    check("full_empty", bus.empty, 0);

    bus.dis_e_ = 1'b0;
    bus.dis_rd = 5'd9;
    tick();
    bus.dis_e_ = 1'b1;
    #1;
    check("ovf_cnt",   dut.u_ptr.cnt_q, 8);
    check("ovf_tag",   bus.dis_tag, 0);
    check("ovf_rd0",   bus.com_rd, 1);
    check("ovf_valid", dut.valid_vec, 8'hFF);

    // out-of-order completion 2,1,0
    bus.wb_e_  = 1'b0;
    bus.wb_tag = 3'd2;
    tick();
    check("wb2_no_ret", bus.com_e_, 1);
    bus.wb_tag = 3'd1;
    tick();
    check("wb1_no_ret", bus.com_e_, 1);
    bus.wb_tag = 3'd0;
    #1;
    check("wb0_same_cyc", bus.com_e_, 1);
    tick();
    bus.wb_e_ = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("ret_com_e_", bus.com_e_,   0);
      check("ret_tag",    bus.com_tag,  i);
      check("ret_rd",     bus.com_rd,   i + 1);
      check("ret_inv_e_", bus.inv_e_,   0);
      check("ret_inv_a",  bus.inv_addr, i);
      tick();
    end
    check("ret_stop", bus.com_e_, 1);
    check("ret_cnt",  dut.u_ptr.cnt_q, 5);

    // refill across the wrap: tags 0,1,2
    for (int i = 0; i < 3; i++) begin
      bus.dis_e_ = 1'b0;
      bus.dis_wv = 1'b1;
      bus.dis_rd = 5'(i + 9);
      #1;
      check("wrap_tag", bus.dis_tag, i);
      tick();
    end
    bus.dis_e_ = 1'b1;

    // full with head done: dispatch in retire cycle rejected
    bus.wb_e_  = 1'b0;
    bus.wb_tag = 3'd3;
    tick();
    bus.wb_e_  = 1'b1;
    bus.dis_e_ = 1'b0;
    bus.dis_rd = 5'd20;
    #1;
    check("fr_com_e_", bus.com_e_,    0);
    check("fr_ready",  bus.dis_ready, 0);
    tick();
    check("fr_cnt_after_ret", dut.u_ptr.cnt_q, 7);
    check("fr_ready2",  bus.dis_ready, 1);
    check("fr_tag2",    bus.dis_tag,   3);
    tick();
    bus.dis_e_ = 1'b1;
    #1;
    check("fr_cnt8", dut.u_ptr.cnt_q, 8);
    check("fr_head", bus.com_tag, 4);

    // flush together with dispatch and writeback
    flush_     = 1'b0;
    bus.dis_e_ = 1'b0;
    bus.wb_e_  = 1'b0;
    bus.wb_tag = 3'd4;
    tick();
    idle();
    #1;
    check("fl_cnt",   dut.u_ptr.cnt_q, 0);
    check("fl_valid", dut.valid_vec, 0);
    check("fl_empty", bus.empty, 1);
    check("fl_tag",   bus.dis_tag, 0);
    check("fl_com_e_", bus.com_e_, 1);

    // no-destination instruction
    bus.dis_e_ = 1'b0;
    bus.dis_wv = 1'b0;
    bus.dis_rd = 5'd7;
    tick();
    bus.dis_e_ = 1'b1;
    bus.wb_e_  = 1'b0;
    bus.wb_tag = 3'd0;
    tick();
    bus.wb_e_ = 1'b1;
    #1;
    check("nowv_com_e_", bus.com_e_, 0);
    check("nowv_inv_e_", bus.inv_e_, 1);
    check("nowv_com_wv", bus.com_wv, 0);
    tick();
    check("nowv_empty", bus.empty, 1);

    // writeback to the tag being allocated is dropped
    bus.dis_e_ = 1'b0;
    bus.dis_wv = 1'b1;
    bus.dis_rd = 5'd4;
    bus.wb_e_  = 1'b0;
    bus.wb_tag = 3'd1;
    tick();
    idle();
    tick();
    check("alloc_wb_drop", bus.com_e_, 1);

    // exception at head
    flush_ = 1'b0;
    tick();
    flush_     = 1'b1;
    bus.dis_e_ = 1'b0;
    bus.dis_rd = 5'd3;
    tick();
    bus.dis_e_ = 1'b1;
    bus.wb_e_  = 1'b0;
    bus.wb_tag = 3'd0;
    bus.wb_exp = 1'b1;
    tick();
    idle();
    for (int i = 0; i < 5; i++) begin
      check("exc_req_", bus.exc_req_, 0);
      check("exc_com_e_", bus.com_e_, 1);
      check("exc_inv_e_", bus.inv_e_, 1);
      tick();
    end
    flush_ = 1'b0;
    tick();
    flush_ = 1'b1;
    #1;
    check("exc_fl_empty", bus.empty, 1);
    check("exc_fl_tag",   bus.dis_tag, 0);
    check("exc_fl_req_",  bus.exc_req_, 1);

    // asynchronous reset mid-stream
    bus.dis_e_ = 1'b0;
    bus.dis_rd = 5'd6;
    tick();
    tick();
    bus.dis_e_ = 1'b1;
    #1;
    check("ar_pre_cnt", dut.u_ptr.cnt_q, 2);
    reset_ = 1'b0;
    #1;
    check("ar_cnt",   dut.u_ptr.cnt_q, 0);
    check("ar_valid", dut.valid_vec, 0);
    check("ar_empty", bus.empty, 1);
    check("ar_tag",   bus.dis_tag, 0);
    tick();
    reset_ = 1'b1;
    tick();
    check("ar_ready", bus.dis_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
